// File: rtl/rx_sample_pack_buffer.sv
// Packs consecutive RX samples into wide words and buffers them in a circular BRAM FIFO
// that the DRAM controller drains one word per request.
module rx_sample_pack_buffer #(
   parameter int unsigned DATA_W           = 16,
   parameter int unsigned SAMPLES_PER_WORD = 16,
   parameter int unsigned ADDR_W           = 6,
   parameter int unsigned BURST_LEN        = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [DATA_W-1:0]                    rx_data,
   input  logic                                 rx_valid,
   input  logic                                 BRAM_rd_request,
   output logic [DATA_W*SAMPLES_PER_WORD-1:0]   BRAM_rd_data,
   output logic                                 BRAM_rd_valid,
   output logic                                 BRAM_ready,
   output logic [ADDR_W:0]                      fifo_count,
   output logic                                 overflow
);

   localparam int unsigned WORD_W = DATA_W * SAMPLES_PER_WORD;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;
   localparam int unsigned IDX_W  = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;

   localparam logic [ADDR_W:0] C_DEPTH = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0] C_BURST = BURST_LEN[ADDR_W:0];
   localparam logic [IDX_W-1:0] C_LAST = IDX_W'(SAMPLES_PER_WORD - 1);

   // Pack stage
   logic [IDX_W-1:0]  r_idx;
   logic [WORD_W-1:0] r_pack;
   logic [WORD_W-1:0] w_pack_next;
   logic [WORD_W-1:0] r_wr_word;
   logic              r_wr_stb;

   // FIFO state
   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic [ADDR_W:0]   w_count_next;
   logic              w_wr_acc;
   logic              w_rd_acc;
   logic              w_wr_drop;

   logic [WORD_W-1:0] r_rd_data;
   logic              r_rd_valid;
   logic              r_ready;
   logic              r_overflow;

   always_comb begin
      w_pack_next = r_pack;
      w_pack_next[DATA_W*r_idx +: DATA_W] = rx_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx     <= '0;
         r_pack    <= '0;
         r_wr_word <= '0;
         r_wr_stb  <= 1'b0;
      end else begin
         r_wr_stb <= 1'b0;
         if (rx_valid) begin
            r_pack <= w_pack_next;
            if (r_idx == C_LAST) begin
               r_idx     <= '0;
               r_wr_word <= w_pack_next;
               r_wr_stb  <= 1'b1;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end
      end
   end

   // Full/empty decisions use the registered count, so a same-address read and write
   // can never coincide.
   assign w_wr_acc  = r_wr_stb && (r_count != C_DEPTH);
   assign w_wr_drop = r_wr_stb && (r_count == C_DEPTH);
   assign w_rd_acc  = BRAM_rd_request && (r_count != '0);

   always_comb begin
      w_count_next = r_count;
      unique case ({w_wr_acc, w_rd_acc})
         2'b10:   w_count_next = r_count + 1'b1;
         2'b01:   w_count_next = r_count - 1'b1;
         default: w_count_next = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= r_wr_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_ready    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_count    <= w_count_next;
         r_ready    <= (w_count_next >= C_BURST);
         r_rd_valid <= w_rd_acc;
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_acc) begin
            r_rd_data <= r_mem[r_rd_ptr];
            r_rd_ptr  <= r_rd_ptr + 1'b1;
         end
         if (w_wr_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign BRAM_rd_data  = r_rd_data;
   assign BRAM_rd_valid = r_rd_valid;
   assign BRAM_ready    = r_ready;
   assign fifo_count    = r_count;
   assign overflow      = r_overflow;

endmodule

// File: tb/tb_rx_sample_pack_buffer.sv
// Directed bench for rx_sample_pack_buffer: a queue-based FIFO model is compared against the
// DUT after every clock edge, with literal expectations pinning the key scenarios.
module tb_rx_sample_pack_buffer;

   logic         clk;
   logic         rst_n;
   logic [15:0]  rx_data;
   logic         rx_valid;
   logic         BRAM_rd_request;
   logic [255:0] BRAM_rd_data;
   logic         BRAM_rd_valid;
   logic         BRAM_ready;
   logic [6:0]   fifo_count;
   logic         overflow;

   int n_checks = 0;
   int n_errors = 0;

   // Model state
   logic [15:0]  m_lane [16];
   int           m_idx;
   logic         m_pend;
   logic [255:0] m_pend_word;
   logic [255:0] m_q [$];
   logic         m_ovf;
   logic         m_rd_valid;
   logic [255:0] m_rd_data;
   int           s_cnt;

   localparam logic [255:0] WORD0 =
      256'h000F000E000D000C000B000A0009000800070006000500040003000200010000;

   rx_sample_pack_buffer #(
      .DATA_W(16), .SAMPLES_PER_WORD(16), .ADDR_W(6), .BURST_LEN(16)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rx_data         (rx_data),
      .rx_valid        (rx_valid),
      .BRAM_rd_request (BRAM_rd_request),
      .BRAM_rd_data    (BRAM_rd_data),
      .BRAM_rd_valid   (BRAM_rd_valid),
      .BRAM_ready      (BRAM_ready),
      .fifo_count      (fifo_count),
      .overflow        (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 16; k++) m_lane[k] = '0;
      m_idx      = 0;
      m_pend     = 1'b0;
      m_pend_word = '0;
      m_q.delete();
      m_ovf      = 1'b0;
      m_rd_valid = 1'b0;
      m_rd_data  = '0;
   endtask

   task automatic model_edge(input logic v, input logic [15:0] d, input logic req);
      int old_n;
      bit rd_ok;
      bit wr_ok;
      old_n = m_q.size();
      rd_ok = req && (old_n > 0);
      wr_ok = m_pend && (old_n < 64);
      if (m_pend && !wr_ok) m_ovf = 1'b1;
      if (rd_ok) m_rd_data = m_q.pop_front();
      if (wr_ok) m_q.push_back(m_pend_word);
      m_rd_valid = rd_ok;
      m_pend = 1'b0;
      if (v) begin
         m_lane[m_idx] = d;
         if (m_idx == 15) begin
            for (int k = 0; k < 16; k++) m_pend_word[16*k +: 16] = m_lane[k];
            m_pend = 1'b1;
            m_idx  = 0;
         end else begin
            m_idx++;
         end
      end
   endtask

   task automatic compare();
      chk("fifo_count", 256'(fifo_count), 256'(m_q.size()));
      chk("ready", 256'(BRAM_ready), 256'(m_q.size() >= 16));
      chk("overflow", 256'(overflow), 256'(m_ovf));
      chk("rd_valid", 256'(BRAM_rd_valid), 256'(m_rd_valid));
      chk("rd_data", BRAM_rd_data, m_rd_data);
   endtask

   task automatic step(input logic v, input logic [15:0] d, input logic req);
      rx_valid        = v;
      rx_data         = d;
      BRAM_rd_request = req;
      @(posedge clk);
      #1;
      model_edge(v, d, req);
      compare();
      rx_valid        = 1'b0;
      BRAM_rd_request = 1'b0;
   endtask

   task automatic sample(input logic req);
      step(1'b1, 16'(s_cnt * 40503 + 7), req);
      s_cnt++;
   endtask

   task automatic words(input int n);
      for (int i = 0; i < n * 16; i++) sample(1'b0);
   endtask

   task automatic check_zero_outputs();
      chk("rst_rd_data", BRAM_rd_data, '0);
      chk("rst_rd_valid", 256'(BRAM_rd_valid), '0);
      chk("rst_ready", 256'(BRAM_ready), '0);
      chk("rst_count", 256'(fifo_count), '0);
      chk("rst_overflow", 256'(overflow), '0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check_zero_outputs();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      rx_data = '0;
      rx_valid = 1'b0;
      BRAM_rd_request = 1'b0;
      s_cnt = 0;
      model_reset();
      #12;
      do_reset();

      // 1: one word 0..F
      for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0);
      chk("t1_count_before_store", 256'(fifo_count), 256'd0);
      step(1'b0, '0, 1'b0);
      chk("t1_count", 256'(fifo_count), 256'd1);
      step(1'b0, '0, 1'b1);
      chk("t1_word", BRAM_rd_data, WORD0);
      chk("t1_valid", 256'(BRAM_rd_valid), 256'd1);

      // 2: a full burst, then drained back-to-back
      words(15);
      for (int i = 0; i < 15; i++) sample(1'b0);
      chk("t2_ready_before", 256'(BRAM_ready), 256'd0);
      sample(1'b0);
      step(1'b0, '0, 1'b0);
      chk("t2_count", 256'(fifo_count), 256'd16);
      chk("t2_ready", 256'(BRAM_ready), 256'd1);
      for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
      chk("t2_count_end", 256'(fifo_count), 256'd0);
      chk("t2_ready_end", 256'(BRAM_ready), 256'd0);

      // 4: request at empty
      step(1'b0, '0, 1'b1);
      chk("t4_valid", 256'(BRAM_rd_valid), 256'd0);
      chk("t4_count", 256'(fifo_count), 256'd0);

      // 3: overflow
      words(64);
      step(1'b0, '0, 1'b0);
      chk("t3_full", 256'(fifo_count), 256'd64);
      chk("t3_no_ovf_yet", 256'(overflow), 256'd0);
      words(1);
      step(1'b0, '0, 1'b0);
      chk("t3_ovf", 256'(overflow), 256'd1);
      chk("t3_count", 256'(fifo_count), 256'd64);
      for (int i = 0; i < 64; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      chk("t3_drained", 256'(fifo_count), 256'd0);
      chk("t3_ovf_sticky", 256'(overflow), 256'd1);

      // 5: simultaneous write+read at count 20, then pointer wrap
      do_reset();
      words(20);
      for (int i = 0; i < 16; i++) sample(1'b0);
      step(1'b0, '0, 1'b0);
      chk("t5_count21", 256'(fifo_count), 256'd21);
      step(1'b0, '0, 1'b1);
      chk("t5_count20", 256'(fifo_count), 256'd20);
      for (int i = 0; i < 15; i++) sample(1'b0);
      sample(1'b0);
      step(1'b0, '0, 1'b1);
      chk("t5_same_cycle", 256'(fifo_count), 256'd20);
      for (int w = 0; w < 78; w++) begin
         for (int i = 0; i < 16; i++) sample(i == 3);
      end
      step(1'b0, '0, 1'b0);
      for (int i = 0; i < 200 && m_q.size() > 0; i++) step(1'b0, '0, 1'b1);
      chk("t5_drained", 256'(fifo_count), 256'd0);

      // 6: reset mid-pack and mid-burst
      words(16);
      step(1'b0, '0, 1'b0);
      for (int i = 0; i < 7; i++) sample(1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero_outputs();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0);
      step(1'b0, '0, 1'b0);
      chk("t6_count", 256'(fifo_count), 256'd1);
      step(1'b0, '0, 1'b1);
      chk("t6_word", BRAM_rd_data, WORD0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
